// File: rtl/pwm4.sv
// ---------------------------------------------------------------------------
// pwm4 -- 4-bit PWM generator slaved to an external free-running timebase.
//
// The upstream 4-bit counter `count` defines a 16-tick period. Once enabled,
// the block waits for the next timebase wrap (count==F). It then produces one
// PWM period per timebase revolution. Each period starts at count==0 and is
// high for `duty_act` ticks. Duty changes are staged in a shadow register and
// take effect only at a period boundary, so a period is never torn.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-low reset
//   count       in   4  free-running timebase (+1 per clk, wraps F->0)
//   en          in   1  run request, level-sensitive
//   duty        in   4  requested high time in ticks (0..15)
//   duty_wr     in   1  one-cycle strobe: capture duty into the shadow reg
//   pwm         out  1  registered PWM output (1 clk after count)
//   period_end  out  1  registered one-cycle pulse at the end of each period
//   busy        out  1  high while the controller is ARM, RUN or DRAIN
//   wrap_cnt    out  8  completed-period counter (PWM4_WRAPCNT_EN only)
//
// Build option
//   PWM4_WRAPCNT_EN  adds the wrap_cnt port and its 8-bit counter. Without
//                    it the port and register are absent. Everything else
//                    behaves the same way.
//
// FSM
//   IDLE  -> ARM   en=1
//   ARM   -> IDLE  en=0 (wins over everything else)
//   ARM   -> RUN   count==F, so the first period starts at count==0
//   RUN   -> DRAIN en=0 mid-period: the current period finishes first
//   RUN   -> IDLE  en=0 exactly at count==F (period already complete)
//   DRAIN -> IDLE  count==F, en ignored
// ---------------------------------------------------------------------------
module pwm4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       en,
    input  logic [3:0] duty,
    input  logic       duty_wr,
    output logic       pwm,
    output logic       period_end,
    output logic       busy
`ifdef PWM4_WRAPCNT_EN
    ,
    output logic [7:0] wrap_cnt
`endif
);

    // State encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    logic [3:0] duty_shd;
    logic [3:0] duty_act;

    // count==F marks the last tick of a period. The next tick (count==0)
    // opens a new one.
    logic at_wrap;
    // RUN and DRAIN both drive the waveform; DRAIN only finishes it.
    logic active;
    // ARM, RUN and DRAIN all follow the timebase for duty reloads.
    logic engaged;

    assign at_wrap = (count == 4'hF);
    assign active  = (state == ST_RUN) || (state == ST_DRAIN);
    assign engaged = (state != ST_IDLE);

    assign busy = engaged;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (at_wrap) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = at_wrap ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (at_wrap) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Duty registers
    //
    // duty_wr is a plain one-cycle strobe with no back-pressure: the value
    // on duty is taken on every edge where duty_wr=1.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_shd <= 4'h0;
        end else if (duty_wr) begin
            duty_shd <= duty;
        end
    end

    // Reload at the period boundary. A write that arrives on that same edge
    // has not reached duty_shd yet, so it is forwarded straight from the
    // input. Otherwise it would slip a whole period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_act <= 4'h0;
        end else if (engaged && at_wrap) begin
            duty_act <= duty_wr ? duty : duty_shd;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Unsigned 4-bit compare: duty 0 never goes high, duty 15 misses only
    // the count==F tick. The compare uses the duty_act value from before
    // the reload, so the final tick of a period still belongs to it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= active && (count < duty_act);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_end <= 1'b0;
        end else begin
            period_end <= active && at_wrap;
        end
    end

`ifdef PWM4_WRAPCNT_EN
    // Steps on the same edge that raises period_end. It wraps naturally at
    // 8 bits and only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_cnt <= 8'h00;
        end else if (active && at_wrap) begin
            wrap_cnt <= wrap_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_pwm4.sv
// ---------------------------------------------------------------------------
// tb_pwm4 -- self-checking bench for pwm4.
//
// A behavioural model predicts pwm, period_end, busy (and wrap_cnt when
// PWM4_WRAPCNT_EN is defined) on every clock. Directed scenarios cover start
// alignment, duty updates, bypass, limits, drain and reset. A randomized
// phase follows.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       en;
  logic [3:0] duty;
  logic       duty_wr;
  logic       pwm;
  logic       period_end;
  logic       busy;
`ifdef PWM4_WRAPCNT_EN
  logic [7:0] wrap_cnt;
`endif

  always #5 clk = ~clk;

  pwm4 dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .en         (en),
    .duty       (duty),
    .duty_wr    (duty_wr),
    .pwm        (pwm),
    .period_end (period_end),
    .busy       (busy)
`ifdef PWM4_WRAPCNT_EN
    ,
    .wrap_cnt   (wrap_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of the generator, described by what the output is doing.
  typedef enum logic [1:0] {M_OFF, M_WAIT, M_ON, M_FINISH} m_phase_t;
  m_phase_t   m_ph;
  logic [3:0] m_shd;
  logic [3:0] m_act;
  logic       m_pwm;
  logic       m_pe;
  logic [7:0] m_wrap;

  task automatic model_reset();
    m_ph   = M_OFF;
    m_shd  = 4'h0;
    m_act  = 4'h0;
    m_pwm  = 1'b0;
    m_pe   = 1'b0;
    m_wrap = 8'h00;
  endtask

  // Apply one clock edge using the inputs currently presented.
  task automatic model_edge();
    bit outputting;
    bit last_tick;
    outputting = (m_ph == M_ON) || (m_ph == M_FINISH);
    last_tick  = (count == 4'd15);
    m_pwm = outputting && (int'(count) < int'(m_act));
    m_pe  = outputting && last_tick;
    if (m_pe) m_wrap = m_wrap + 8'd1;
    if (last_tick && m_ph != M_OFF) m_act = duty_wr ? duty : m_shd;
    if (duty_wr) m_shd = duty;
    case (m_ph)
      M_OFF:    if (en) m_ph = M_WAIT;
      M_WAIT:   if (!en) m_ph = M_OFF; else if (last_tick) m_ph = M_ON;
      M_ON:     if (!en) m_ph = last_tick ? M_OFF : M_FINISH;
      M_FINISH: if (last_tick) m_ph = M_OFF;
      default:  m_ph = M_OFF;
    endcase
  endtask

  task automatic compare_outputs(input string where);
    check({where, ":pwm"},        32'(pwm),        32'(m_pwm));
    check({where, ":period_end"}, 32'(period_end), 32'(m_pe));
    check({where, ":busy"},       32'(busy),       32'(m_ph != M_OFF));
`ifdef PWM4_WRAPCNT_EN
    check({where, ":wrap_cnt"},   32'(wrap_cnt),   32'(m_wrap));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict, clock, check #1 later, then advance the timebase.
  task automatic tick();
    if (rst) model_edge();
    @(posedge clk);
    #1;
    compare_outputs("cyc");
    count   = count + 4'd1;
    duty_wr = 1'b0;
  endtask

  // Assert reset between clock edges and check outputs before any edge.
  task automatic async_reset(input int hold_cycles);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_async:pwm",        32'(pwm),        32'(0));
    check("rst_async:period_end", 32'(period_end), 32'(0));
    check("rst_async:busy",       32'(busy),       32'(0));
`ifdef PWM4_WRAPCNT_EN
    check("rst_async:wrap_cnt",   32'(wrap_cnt),   32'(0));
`endif
    for (int i = 0; i < hold_cycles; i++) tick();
    rst = 1'b1;
  endtask

  // Wait for a period start, then count highs and pulses over 16 ticks.
  // Optionally write wr_val at the tick where count==wr_at.
  task automatic measure_period(input string tag, input int exp_high,
                                input int wr_at, input logic [3:0] wr_val);
    int guard;
    int highs;
    int pes;
    guard = 0;
    while (!(count == 4'd0 && m_ph == M_ON) && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) begin
      check({tag, ":start_timeout"}, 32'(guard), 32'(0));
    end else begin
      highs = 0;
      pes   = 0;
      for (int i = 0; i < 16; i++) begin
        if (wr_at >= 0 && int'(count) == wr_at) begin
          duty    = wr_val;
          duty_wr = 1'b1;
        end
        tick();
        highs += int'(pwm);
        pes   += int'(period_end);
      end
      check({tag, ":high_cycles"}, 32'(highs), 32'(exp_high));
      check({tag, ":period_ends"}, 32'(pes),   32'(1));
    end
  endtask

  task automatic wait_count(input logic [3:0] target);
    int guard;
    guard = 0;
    while (count != target && guard < 32) begin
      tick();
      guard++;
    end
    if (guard >= 32) check("wait_count_timeout", 32'(guard), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    int pes;
    rst     = 1'b0;
    en      = 1'b0;
    duty    = 4'h0;
    duty_wr = 1'b0;
    count   = 4'h0;
    model_reset();

    // Reset values before any clock edge.
    #2;
    check("por:pwm",        32'(pwm),        32'(0));
    check("por:period_end", 32'(period_end), 32'(0));
    check("por:busy",       32'(busy),       32'(0));
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Start alignment: duty 4, enable at count 7.
    duty = 4'd4;
    duty_wr = 1'b1;
    tick();
    wait_count(4'd7);
    en = 1'b1;
    tick();
    check("start:busy", 32'(busy), 32'(1));
    measure_period("start", 4, -1, 4'd0);
    measure_period("start2", 4, -1, 4'd0);

    // Mid-period update takes effect only in the next period.
    measure_period("upd_cur", 4, 5, 4'd12);
    measure_period("upd_next", 12, -1, 4'd0);

    // Write on the count==F edge is forwarded into the next period.
    measure_period("byp_cur", 12, 15, 4'd9);
    measure_period("byp_next", 9, -1, 4'd0);

    // Limits.
    measure_period("lim_to0", 9, 3, 4'd0);
    measure_period("lim_0", 0, -1, 4'd0);
    measure_period("lim_to15", 0, 3, 4'd15);
    measure_period("lim_15", 15, -1, 4'd0);

    // Drain: drop en at count 3, the period completes with one pulse.
    wait_count(4'd3);
    en = 1'b0;
    pes = 0;
    guard = 0;
    do begin
      tick();
      pes += int'(period_end);
      guard++;
    end while (busy && guard < 40);
    check("drain:period_ends", 32'(pes), 32'(1));
    check("drain:busy", 32'(busy), 32'(0));
    check("drain:cycles", 32'(guard), 32'(13));

    // Reset mid-run while pwm is high, then stay idle with en=0.
    duty = 4'd8;
    duty_wr = 1'b1;
    en = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!pwm && guard < 80);
    check("midrst:pwm_before", 32'(pwm), 32'(1));
    en = 1'b0;
    async_reset(2);
    for (int i = 0; i < 20; i++) tick();
    check("midrst:idle", 32'(busy), 32'(0));

`ifdef PWM4_WRAPCNT_EN
    // 256 periods from reset bring wrap_cnt back to zero.
    async_reset(1);
    duty = 4'd5;
    duty_wr = 1'b1;
    en = 1'b1;
    pes = 0;
    guard = 0;
    while (pes < 256 && guard < 5000) begin
      tick();
      pes += int'(period_end);
      guard++;
    end
    check("wrap256:periods", 32'(pes), 32'(256));
    check("wrap256:wrap_cnt", 32'(wrap_cnt), 32'(0));
    en = 1'b0;
`endif

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) begin
        duty    = 4'($urandom_range(0, 15));
        duty_wr = 1'b1;
      end
      if ($urandom_range(0, 599) == 0) begin
        async_reset($urandom_range(0, 2));
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
